// File: rtl/tile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_sequencer_pkg
//  Description : Shared constants for the tile sequencer: FSM state codes,
//                row-code width, empty-row code, LFSR tap mask and a
//                row-code to key-column one-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tile_sequencer_pkg;

    // Width of one row code (0 = empty, 1..4 = tile column)
    localparam int C_ROW_W = 3;

    localparam logic [C_ROW_W-1:0] C_ROW_EMPTY = 3'd0;

    // FSM state encodings (also exported on state_dbg)
    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_WAIT_TICK = 3'd1;
    localparam logic [2:0] C_ST_DRAW      = 3'd2;
    localparam logic [2:0] C_ST_RELEASE   = 3'd3;
    localparam logic [2:0] C_ST_ADVANCE   = 3'd4;
    localparam logic [2:0] C_ST_GAME_OVER = 3'd5;

    // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] C_LFSR_TAPS = 8'hB8;

    // Key pattern that correctly hits a row holding the given code
    function automatic logic [3:0] col_onehot(input logic [C_ROW_W-1:0] code);
        logic [3:0] mask;
        case (code)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0010;
            3'd3:    mask = 4'b0100;
            3'd4:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : tile_lfsr
//  Description : 8-bit right-shifting Galois LFSR with step enable and seed
//                load. Exposes its low OUT_W bits as the random draw.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_lfsr
    import tile_sequencer_pkg::*;
#(
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         OUT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    output logic [OUT_W-1:0] o_bits
);

    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_nx;

    // One Galois step: shift right, fold the tap mask in when a 1 falls out
    always_comb begin
        w_lfsr_nx = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? C_LFSR_TAPS : 8'h00);
    end

    // Seed on reset or load request, otherwise advance when asked
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= w_lfsr_nx;
        end
    end

    assign o_bits = r_lfsr[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_sequencer
//  Description : Game-level sequencer feeding the row display controller.
//                Paces draws on a frame tick, scrolls the row queue, spawns
//                pseudo-random rows, resolves key hits against the bottom
//                row, keeps the score and flags game over.
//                NUM_ROWS must be at least 2.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_sequencer
    import tile_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_DIV  = 833334,
    parameter int unsigned ROW_HEIGHT = 40,
    parameter int unsigned NUM_ROWS   = 4,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [3:0]            key_press,
    input  logic                  all_done,
    output logic                  startdraw,
    output logic [5:0]            offset,
    output logic [3*NUM_ROWS-1:0] rows,
    output logic [7:0]            score,
    output logic                  game_over,
    output logic [2:0]            state_dbg
);

    localparam int                 C_CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(FRAME_DIV - 1);
    localparam logic [5:0]         C_OFF_MAX = 6'(ROW_HEIGHT - 1);
    localparam int                 C_RW      = C_ROW_W * NUM_ROWS;

    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_frame_cnt;
    logic               r_tick_pending;
    logic [5:0]         r_offset;
    logic [C_RW-1:0]    r_rows;
    logic [7:0]         r_score;

    logic               w_play;
    logic               w_wrap;
    logic [C_ROW_W-1:0] w_bottom;
    logic               w_key_any;
    logic               w_key_good;
    logic [C_RW-1:0]    w_rows_hit;
    logic [7:0]         w_score_hit;
    logic [1:0]         w_lfsr_bits;
    logic [C_ROW_W-1:0] w_new_code;
    logic               w_lfsr_step;
    logic [2:0]         w_state_nx;
    logic [5:0]         w_offset_nx;
    logic [C_RW-1:0]    w_rows_nx;
    logic [7:0]         w_score_nx;

    tile_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (2)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .i_load (1'b0),
        .i_step (w_lfsr_step),
        .o_bits (w_lfsr_bits)
    );

    assign w_play = (r_state == C_ST_WAIT_TICK) || (r_state == C_ST_DRAW) ||
                    (r_state == C_ST_RELEASE)   || (r_state == C_ST_ADVANCE);
    assign w_wrap     = (r_frame_cnt == C_CNT_MAX);
    assign w_bottom   = r_rows[C_RW-1 -: C_ROW_W];
    assign w_key_any  = (key_press != 4'b0000);
    assign w_key_good = (w_bottom != C_ROW_EMPTY) && (key_press == col_onehot(w_bottom));
    assign w_new_code = {1'b0, w_lfsr_bits} + 3'd1;

    // Apply a correct hit first so the scroll and miss check see the cleared row
    always_comb begin
        w_rows_hit  = r_rows;
        w_score_hit = r_score;
        if (w_key_good) begin
            w_rows_hit[C_RW-1 -: C_ROW_W] = C_ROW_EMPTY;
            w_score_hit = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
        end
    end

    // Next-state decision: start beats everything, a bad key beats the FSM
    always_comb begin
        w_state_nx  = r_state;
        w_offset_nx = r_offset;
        w_rows_nx   = r_rows;
        w_score_nx  = r_score;
        w_lfsr_step = 1'b0;
        if (start) begin
            w_state_nx  = C_ST_WAIT_TICK;
            w_offset_nx = '0;
            w_rows_nx   = '0;
            w_score_nx  = '0;
        end else if (w_play && w_key_any && !w_key_good) begin
            w_state_nx = C_ST_GAME_OVER;
        end else if (w_play) begin
            w_rows_nx  = w_rows_hit;
            w_score_nx = w_score_hit;
            case (r_state)
                C_ST_WAIT_TICK: if (r_tick_pending) w_state_nx = C_ST_DRAW;
                C_ST_DRAW:      if (all_done)       w_state_nx = C_ST_RELEASE;
                C_ST_RELEASE:   if (!all_done)      w_state_nx = C_ST_ADVANCE;
                C_ST_ADVANCE: begin
                    w_state_nx = C_ST_WAIT_TICK;
                    if (r_offset < C_OFF_MAX) begin
                        w_offset_nx = r_offset + 6'd1;
                    end else begin
                        w_offset_nx = '0;
                        w_lfsr_step = 1'b1;
                        if (w_rows_hit[C_RW-1 -: C_ROW_W] != C_ROW_EMPTY) begin
                            w_state_nx = C_ST_GAME_OVER;
                        end else begin
                            w_rows_nx = {w_rows_hit[C_RW-C_ROW_W-1:0], w_new_code};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame divider and single-entry tick latch; idle outside play
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_frame_cnt    <= '0;
            r_tick_pending <= 1'b0;
        end else if (start || !w_play) begin
            r_frame_cnt    <= '0;
            r_tick_pending <= 1'b0;
        end else begin
            r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + C_CNT_W'(1);
            if ((r_state == C_ST_WAIT_TICK) && r_tick_pending) begin
                r_tick_pending <= 1'b0;
            end else if (w_wrap) begin
                r_tick_pending <= 1'b1;
            end
        end
    end

    // Game state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= C_ST_IDLE;
            r_offset <= '0;
            r_rows   <= '0;
            r_score  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_offset <= w_offset_nx;
            r_rows   <= w_rows_nx;
            r_score  <= w_score_nx;
        end
    end

    assign startdraw = (r_state == C_ST_DRAW);
    assign game_over = (r_state == C_ST_GAME_OVER);
    assign state_dbg = r_state;
    assign offset    = r_offset;
    assign rows      = r_rows;
    assign score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_sequencer
//  Description : Scoreboard bench for tile_sequencer. A game-level model
//                predicts the outputs after every clock edge; a monitor
//                compares them against the DUT on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_sequencer;

    localparam int         FRAME_DIV  = 4;
    localparam int         ROW_HEIGHT = 4;
    localparam int         NUM_ROWS   = 4;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

    localparam int P_IDLE = 0, P_WAIT = 1, P_DRAW = 2, P_REL = 3, P_ADV = 4, P_OVER = 5;

    logic                  clk = 1'b0;
    logic                  resetn, start, all_done;
    logic [3:0]            key_press;
    logic                  startdraw, game_over;
    logic [5:0]            offset;
    logic [3*NUM_ROWS-1:0] rows;
    logic [7:0]            score;
    logic [2:0]            state_dbg;

    typedef struct packed {
        logic                  sd;
        logic [5:0]            off;
        logic [3*NUM_ROWS-1:0] rws;
        logic [7:0]            sc;
        logic                  go;
        logic [2:0]            st;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_cyc = 0;

    // Game model: rows queue front = top row, back = bottom row
    int m_phase, m_cyc, m_offset, m_score, m_lfsr;
    bit m_pending;
    int m_rows[$];

    tile_sequencer #(
        .FRAME_DIV  (FRAME_DIV),
        .ROW_HEIGHT (ROW_HEIGHT),
        .NUM_ROWS   (NUM_ROWS),
        .LFSR_SEED  (LFSR_SEED)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .key_press (key_press),
        .all_done  (all_done),
        .startdraw (startdraw),
        .offset    (offset),
        .rows      (rows),
        .score     (score),
        .game_over (game_over),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic int lfsr_next(input int l);
        int taps[4] = '{8, 6, 5, 4};
        int mask = 0;
        foreach (taps[i]) mask |= 1 << (taps[i] - 1);
        return (l & 1) ? ((l >> 1) ^ mask) : (l >> 1);
    endfunction

    function automatic logic [3:0] onehot(input int code);
        return 4'(1 << (code - 1));
    endfunction

    function automatic void model_new_game();
        m_offset  = 0;
        m_score   = 0;
        m_cyc     = 0;
        m_pending = 0;
        m_rows.delete();
        repeat (NUM_ROWS) m_rows.push_back(0);
    endfunction

    function automatic void model_step(input bit st, input logic [3:0] kp, input bit ad, input bit rn);
        bit tick, consume;
        int code;
        if (!rn) begin
            m_phase = P_IDLE;
            m_lfsr  = LFSR_SEED;
            model_new_game();
            return;
        end
        if (st) begin
            m_phase = P_WAIT;
            model_new_game();
            return;
        end
        if (!(m_phase inside {[P_WAIT:P_ADV]})) begin
            m_cyc = 0;
            m_pending = 0;
            return;
        end
        if (kp != 4'b0000) begin
            if (m_rows[NUM_ROWS-1] != 0 && kp == onehot(m_rows[NUM_ROWS-1])) begin
                m_rows[NUM_ROWS-1] = 0;
                if (m_score < 255) m_score++;
            end else begin
                m_phase = P_OVER;
                m_cyc = 0;
                m_pending = 0;
                return;
            end
        end
        tick    = (m_cyc == FRAME_DIV - 1);
        m_cyc   = tick ? 0 : m_cyc + 1;
        consume = (m_phase == P_WAIT) && m_pending;
        case (m_phase)
            P_WAIT: if (m_pending) m_phase = P_DRAW;
            P_DRAW: if (ad)        m_phase = P_REL;
            P_REL:  if (!ad)       m_phase = P_ADV;
            default: begin
                m_phase = P_WAIT;
                if (m_offset < ROW_HEIGHT - 1) begin
                    m_offset++;
                end else begin
                    m_offset = 0;
                    code     = (m_lfsr & 3) + 1;
                    m_lfsr   = lfsr_next(m_lfsr);
                    if (m_rows[NUM_ROWS-1] != 0) begin
                        m_phase = P_OVER;
                    end else begin
                        void'(m_rows.pop_back());
                        m_rows.push_front(code);
                    end
                end
            end
        endcase
        if (consume) m_pending = 0;
        else if (tick) m_pending = 1;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.sd  = (m_phase == P_DRAW);
        s.off = 6'(m_offset);
        s.rws = '0;
        for (int i = 0; i < NUM_ROWS; i++) s.rws[3*i +: 3] = 3'(m_rows[i]);
        s.sc  = 8'(m_score);
        s.go  = (m_phase == P_OVER);
        s.st  = 3'(m_phase);
        return s;
    endfunction

    // Monitor: pop one prediction per falling edge and compare all outputs
    always @(negedge clk) begin
        snap_t got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{startdraw, offset, rows, score, game_over, state_dbg};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL outputs cyc %0d: got sd=%0b off=%0d rows=%h score=%0d go=%0b st=%0d, want sd=%0b off=%0d rows=%h score=%0d go=%0b st=%0d",
                         n_cyc, got.sd, got.off, got.rws, got.sc, got.go, got.st,
                         want.sd, want.off, want.rws, want.sc, want.go, want.st);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic cycle(input bit st, input logic [3:0] kp, input bit ad, input bit rn);
        start     = st;
        key_press = kp;
        all_done  = ad;
        resetn    = rn;
        @(posedge clk);
        model_step(st, kp, ad, rn);
        exp_q.push_back(model_snap());
        @(negedge clk);
        n_cyc++;
    endtask

    task automatic wait_phase(input int p, output bit ok);
        int n = 0;
        while (m_phase != p && m_phase != P_OVER && m_phase != P_IDLE && n < 40) begin
            cycle(1'b0, 4'b0000, 1'b0, 1'b1);
            n++;
        end
        ok = (m_phase == p);
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_phase: stuck in phase %0d, want %0d", m_phase, p);
        end
    endtask

    // One draw/release/advance round; optionally hit the bottom row on the wrap cycle
    task automatic drive_frame(input int hold, input bit hit_at_wrap);
        bit         ok;
        logic [3:0] kp;
        wait_phase(P_DRAW, ok);
        if (!ok) return;
        repeat (hold) cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        kp = 4'b0000;
        if (hit_at_wrap && m_phase == P_ADV && m_offset == ROW_HEIGHT - 1 && m_rows[NUM_ROWS-1] != 0)
            kp = onehot(m_rows[NUM_ROWS-1]);
        cycle(1'b0, kp, 1'b0, 1'b1);
    endtask

    initial begin
        bit ok;
        start = 1'b0; key_press = 4'b0000; all_done = 1'b0; resetn = 1'b0;

        // Reset and first frame handshake
        repeat (3) cycle(1'b0, 4'b0000, 1'b0, 1'b0);
        chk("reset_state", state_dbg, P_IDLE);
        chk("reset_rows", rows, 0);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("start_state", state_dbg, P_WAIT);
        wait_phase(P_DRAW, ok);
        repeat (10) cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("draw_held", startdraw, 1);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1);
        chk("draw_released", startdraw, 0);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("offset_first", offset, 1);

        // Scroll to the first wrap: seed A5 spawns code 2, next spawn is code 3
        repeat (3) drive_frame(0, 1'b0);
        chk("wrap_offset", offset, 0);
        chk("first_code", rows[2:0], 2);
        repeat (12) drive_frame(1, 1'b0);
        chk("bottom_filled", rows[11:9], 2);

        // Correct key clears the bottom row and scores
        cycle(1'b0, 4'b0010, 1'b0, 1'b1);
        chk("hit_score", score, 1);
        chk("hit_cleared", rows[11:9], 0);
        repeat (4) drive_frame(0, 1'b0);
        chk("no_miss_after_hit", game_over, 0);
        chk("bottom_next", rows[11:9], 3);

        // Wrong key ends the game
        cycle(1'b0, 4'b0001, 1'b0, 1'b1);
        chk("wrong_key_over", game_over, 1);
        chk("wrong_key_state", state_dbg, P_OVER);
        chk("wrong_key_score", score, 1);
        chk("wrong_key_sd", startdraw, 0);

        // Unhit bottom row at a wrap is a miss; restart clears the game
        cycle(1'b1, 4'b0000, 1'b0, 1'b1);
        repeat (20) drive_frame(0, 1'b0);
        chk("miss_over", game_over, 1);
        repeat (3) cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("restart_rows", rows, 0);
        chk("restart_offset", offset, 0);
        chk("restart_score", score, 0);
        chk("restart_state", state_dbg, P_WAIT);

        // Hit on the same cycle as the wrap: scored, no miss
        repeat (16) drive_frame(0, 1'b0);
        repeat (4) drive_frame(0, 1'b1);
        chk("wrap_hit_score", score, 1);
        chk("wrap_hit_no_over", game_over, 0);

        // Reset during DRAW
        wait_phase(P_DRAW, ok);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0);
        chk("reset_in_draw_sd", startdraw, 0);
        chk("reset_in_draw_state", state_dbg, P_IDLE);
        chk("reset_in_draw_score", score, 0);

        // Long game: score saturates at 255
        cycle(1'b1, 4'b0000, 1'b0, 1'b1);
        repeat (16) drive_frame(0, 1'b0);
        for (int k = 0; k < 260; k++) begin
            repeat (4) drive_frame($urandom_range(0, 2), 1'b1);
        end
        chk("score_saturated", score, 255);
        chk("long_game_alive", game_over, 0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            bit         st, rn, ad;
            logic [3:0] kp;
            int         r;
            st = 1'b0; rn = 1'b1; kp = 4'b0000;
            r  = $urandom_range(0, 999);
            if (r < 3) rn = 1'b0;
            else if ((m_phase == P_IDLE || m_phase == P_OVER) && r < 200) st = 1'b1;
            else if (r < 8) st = 1'b1;
            ad = ($urandom_range(0, 1) == 1);
            r  = $urandom_range(0, 99);
            if (m_rows[NUM_ROWS-1] != 0 && r < 15) kp = onehot(m_rows[NUM_ROWS-1]);
            else if (r == 15) kp = 4'($urandom_range(1, 15));
            cycle(st, kp, ad, rn);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
